// File: rtl/row_clear_engine_pkg.sv
// Shared definitions for the row-clear engine and its neighbours.
// Holds the default board geometry, the width derivations used for row
// indices and cleared-row counts, the FSM state encoding and the row-slice
// macro. Keeping these here makes the board, render and scoring blocks agree
// on layout.
// Row r of a flattened board occupies bits [r*BOARD_W +: BOARD_W].
// Row 0 is the top row and row BOARD_H-1 is the bottom row.

`ifndef ROW_CLEAR_ENGINE_PKG_SV
`define ROW_CLEAR_ENGINE_PKG_SV

`define RCE_ROW(bus, r, w) bus[(r)*(w) +: (w)]

package row_clear_engine_pkg;

   localparam int BOARD_W_DEF    = 10;
   localparam int BOARD_H_DEF    = 20;
   localparam int TOTAL_BITS_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } rce_state_e;

   // Width of a row index. Clamped to 1 so a single-row board still
   // gets a legal vector.
   function automatic int rce_y_bits(input int h);
      return (h > 1) ? $clog2(h) : 1;
   endfunction

   // Width able to hold 0..h inclusive.
   function automatic int rce_cnt_bits(input int h);
      return $clog2(h + 1);
   endfunction

endpackage

`endif

// File: rtl/row_clear_engine_if.sv
// Transaction interface of the row-clear engine.
// The master side (piece-lock logic) drives pause, start, clear_total and
// board_in. The slave side (the engine) returns busy, done, board_out,
// rows_cleared, lines_total and scan_row.
// clk and rst_n are not part of the bundle; they stay plain module ports.

interface row_clear_engine_if
   import row_clear_engine_pkg::*;
#(
   parameter int BOARD_W    = BOARD_W_DEF,
   parameter int BOARD_H    = BOARD_H_DEF,
   parameter int Y_BITS     = rce_y_bits(BOARD_H),
   parameter int CNT_BITS   = rce_cnt_bits(BOARD_H),
   parameter int TOTAL_BITS = TOTAL_BITS_DEF
);

   logic                         pause;
   logic                         start;
   logic                         clear_total;
   logic [BOARD_W*BOARD_H-1:0]   board_in;
   logic                         busy;
   logic                         done;
   logic [BOARD_W*BOARD_H-1:0]   board_out;
   logic [CNT_BITS-1:0]          rows_cleared;
   logic [TOTAL_BITS-1:0]        lines_total;
   logic [Y_BITS-1:0]            scan_row;

   modport master (
      output pause, start, clear_total, board_in,
      input  busy, done, board_out, rows_cleared, lines_total, scan_row
   );

   modport slave (
      input  pause, start, clear_total, board_in,
      output busy, done, board_out, rows_cleared, lines_total, scan_row
   );

endinterface

// File: rtl/row_clear_engine_row_full_detect.sv
// row_full_detect: combinational test of whether one row of a flattened
// board is completely filled.
// Ports:
//   board_i   - flattened board, row r at [r*BOARD_W +: BOARD_W]
//   row_sel_i - row index to examine (must be < BOARD_H)
//   full_o    - AND of all BOARD_W cells of the selected row

module row_full_detect
   import row_clear_engine_pkg::*;
#(
   parameter int BOARD_W = BOARD_W_DEF,
   parameter int BOARD_H = BOARD_H_DEF,
   parameter int Y_BITS  = rce_y_bits(BOARD_H)
) (
   input  logic [BOARD_W*BOARD_H-1:0] board_i,
   input  logic [Y_BITS-1:0]          row_sel_i,
   output logic                       full_o
);

   logic [BOARD_W-1:0] row_sel_bits;

   // Explicit per-row mux keeps every slice in range for any select value.
   always_comb begin
      row_sel_bits = '0;
      for (int r = 0; r < BOARD_H; r++) begin
         if (row_sel_i == Y_BITS'(r)) begin
            row_sel_bits = `RCE_ROW(board_i, r, BOARD_W);
         end
      end
   end

   assign full_o = &row_sel_bits;

endmodule

// File: rtl/row_clear_engine.sv
// row_clear_engine: start/done line-clear engine for the playfield.
// On an accepted start the placed-block bitmap is snapshot into a private
// buffer and scanned bottom-up one row per cycle. A full row is removed by
// shifting everything above it down one row and inserting an empty row at
// the top. When the scan passes row 0 the compacted board and the number of
// removed rows are published with a one-cycle done pulse, and the running
// line total is bumped with saturation.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset; abandons any pass in flight
//   bus   - slave modport of row_clear_engine_if:
//           pause (freeze everything), start, clear_total, board_in,
//           busy, done, board_out, rows_cleared, lines_total, scan_row

module row_clear_engine
   import row_clear_engine_pkg::*;
#(
   parameter int BOARD_W    = BOARD_W_DEF,
   parameter int BOARD_H    = BOARD_H_DEF,
   parameter int Y_BITS     = rce_y_bits(BOARD_H),
   parameter int CNT_BITS   = rce_cnt_bits(BOARD_H),
   parameter int TOTAL_BITS = TOTAL_BITS_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   row_clear_engine_if.slave bus
);

   localparam int                NCELLS  = BOARD_W * BOARD_H;
   localparam logic [Y_BITS-1:0] ROW_BOT = Y_BITS'(BOARD_H - 1);

   rce_state_e              state_q, state_d;
   logic [NCELLS-1:0]       buf_q, buf_d;
   logic [CNT_BITS-1:0]     cnt_q, cnt_d;
   logic [Y_BITS-1:0]       row_q, row_d;
   logic [NCELLS-1:0]       board_out_q, board_out_d;
   logic [CNT_BITS-1:0]     rows_q, rows_d;
   logic [TOTAL_BITS-1:0]   total_q, total_d;

   logic [Y_BITS-1:0]       det_sel;
   logic                    det_full;
   logic                    shift_in_full;

   // Drop rows 0..at-1 down by one (row at is overwritten, row 0 becomes
   // empty); rows below 'at' are untouched.
   function automatic logic [NCELLS-1:0] shift_down(
      input logic [NCELLS-1:0] b,
      input logic [Y_BITS-1:0] at
   );
      logic [NCELLS-1:0] s;
      s = b;
      `RCE_ROW(s, 0, BOARD_W) = '0;
      for (int r = 1; r < BOARD_H; r++) begin
         if (Y_BITS'(r) <= at) begin
            `RCE_ROW(s, r, BOARD_W) = `RCE_ROW(b, r - 1, BOARD_W);
         end
      end
      return s;
   endfunction

   function automatic logic [TOTAL_BITS-1:0] sat_add(
      input logic [TOTAL_BITS-1:0] t,
      input logic [CNT_BITS-1:0]   c
   );
      logic [TOTAL_BITS:0] s;
      s = {1'b0, t} + (TOTAL_BITS + 1)'(c);
      return s[TOTAL_BITS] ? '1 : s[TOTAL_BITS-1:0];
   endfunction

   // In SCAN the detector looks at the current row. In SHIFT it looks at
   // the row directly above, i.e. the one that is about to drop into
   // scan_row, so the re-check of the dropped row happens inside the SHIFT
   // cycle and a cleared row costs only one extra cycle.
   assign det_sel = (state_q == ST_SHIFT) ? (row_q - Y_BITS'(1)) : row_q;

   row_full_detect #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H),
      .Y_BITS  (Y_BITS)
   ) u_row_full_detect (
      .board_i   (buf_q),
      .row_sel_i (det_sel),
      .full_o    (det_full)
   );

   // At row 0 the row dropping in is the inserted empty row.
   assign shift_in_full = det_full && (row_q != '0);

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      board_out_d = board_out_q;
      rows_d      = rows_q;
      total_d     = total_q;

      if (!bus.pause) begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  buf_d   = bus.board_in;
                  row_d   = ROW_BOT;
                  cnt_d   = '0;
                  state_d = ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (det_full) begin
                  state_d = ST_SHIFT;
               end else if (row_q != '0) begin
                  row_d = row_q - Y_BITS'(1);
               end else begin
                  // Publish on entry so the results are valid while done is high.
                  state_d     = ST_DONE;
                  board_out_d = buf_q;
                  rows_d      = cnt_q;
               end
            end
            ST_SHIFT: begin
               buf_d = shift_down(buf_q, row_q);
               cnt_d = cnt_q + CNT_BITS'(1);
               if (shift_in_full) begin
                  state_d = ST_SHIFT;
               end else if (row_q != '0) begin
                  state_d = ST_SCAN;
                  row_d   = row_q - Y_BITS'(1);
               end else begin
                  state_d     = ST_DONE;
                  board_out_d = buf_d;
                  rows_d      = cnt_d;
               end
            end
            ST_DONE: begin
               total_d = sat_add(total_q, rows_q);
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase

         if (bus.clear_total) begin
            total_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         buf_q       <= '0;
         cnt_q       <= '0;
         row_q       <= ROW_BOT;
         board_out_q <= '0;
         rows_q      <= '0;
         total_q     <= '0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         board_out_q <= board_out_d;
         rows_q      <= rows_d;
         total_q     <= total_d;
      end
   end

   assign bus.busy         = (state_q == ST_SCAN) || (state_q == ST_SHIFT);
   assign bus.done         = (state_q == ST_DONE);
   assign bus.board_out    = board_out_q;
   assign bus.rows_cleared = rows_q;
   assign bus.lines_total  = total_q;
   assign bus.scan_row     = row_q;

endmodule

// File: tb/tb_row_clear_engine.sv
// Bench for row_clear_engine: directed boards plus randomized boards,
// pauses and start/board_in noise, checked against a queue-based model of
// line clearing and a saturating running total.

module tb_row_clear_engine;
   import row_clear_engine_pkg::*;

   localparam int W  = 10;
   localparam int H  = 20;
   localparam int YB = 5;
   localparam int CB = 5;
   localparam int TB = 12;
   localparam int N  = W * H;
   localparam int TMAX = (1 << TB) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   row_clear_engine_if #(
      .BOARD_W(W), .BOARD_H(H), .Y_BITS(YB), .CNT_BITS(CB), .TOTAL_BITS(TB)
   ) bus ();

   row_clear_engine #(
      .BOARD_W(W), .BOARD_H(H), .Y_BITS(YB), .CNT_BITS(CB), .TOTAL_BITS(TB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total_n = 0;
   int bad_n   = 0;
   int model_total = 0;

   task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Reference: keep every non-full row in bottom-up order, stack them at
   // the bottom of an empty board.
   function automatic logic [N-1:0] model_compact(input logic [N-1:0] b, output int k);
      logic [W-1:0] keep[$];
      logic [N-1:0] o;
      k = 0;
      o = '0;
      for (int r = H - 1; r >= 0; r--) begin
         if (b[r*W +: W] == {W{1'b1}}) k++;
         else keep.push_back(b[r*W +: W]);
      end
      foreach (keep[i]) o[(H-1-i)*W +: W] = keep[i];
      return o;
   endfunction

   function automatic logic [N-1:0] rand_board();
      logic [N-1:0] b;
      b = '0;
      for (int r = 0; r < H; r++) begin
         if ($urandom_range(2) == 0) b[r*W +: W] = '1;
         else b[r*W +: W] = W'($urandom);
      end
      return b;
   endfunction

   task automatic chk_zeroed(input string tag);
      chk({tag, "_busy"},  N'(bus.busy), N'(0));
      chk({tag, "_done"},  N'(bus.done), N'(0));
      chk({tag, "_board"}, bus.board_out, '0);
      chk({tag, "_rows"},  N'(bus.rows_cleared), N'(0));
      chk({tag, "_total"}, N'(bus.lines_total), N'(0));
      chk({tag, "_scan"},  N'(bus.scan_row), N'(H - 1));
   endtask

   // One full transaction. pause_len cycles of pause start at the
   // pause_at-th cycle after acceptance; done_hold pauses in DONE.
   task automatic run_pass(input string tag, input logic [N-1:0] b, input int pause_at,
                           input int pause_len, input int done_hold, input bit clr);
      logic [N-1:0] exp_b;
      int k, lat, exp_lat, sat;
      bit got;
      exp_b = model_compact(b, k);
      exp_lat = H + k + 1 + pause_len;
      @(negedge clk);
      bus.board_in = b;
      bus.start = 1'b1;
      @(posedge clk);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 4 * H + pause_len + 10) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk({tag, "_busy"}, N'(bus.busy), N'(1));
            chk({tag, "_scan0"}, N'(bus.scan_row), N'(H - 1));
         end
         if (bus.done) begin
            got = 1'b1;
         end else begin
            bus.board_in = rand_board();
            bus.start = 1'($urandom_range(1));
            bus.pause = (pause_len > 0) && (lat >= pause_at) && (lat < pause_at + pause_len);
         end
      end
      bus.start = 1'b0;
      bus.pause = 1'b0;
      chk({tag, "_done_seen"}, N'(got), N'(1));
      chk({tag, "_latency"}, N'(lat), N'(exp_lat));
      chk({tag, "_board"}, bus.board_out, exp_b);
      chk({tag, "_rows"}, N'(bus.rows_cleared), N'(k));
      for (int i = 0; i < done_hold; i++) begin
         bus.pause = 1'b1;
         @(negedge clk);
         chk({tag, "_done_held"}, N'(bus.done), N'(1));
      end
      bus.pause = 1'b0;
      bus.clear_total = clr;
      @(negedge clk);
      bus.clear_total = 1'b0;
      sat = model_total + k;
      model_total = clr ? 0 : ((sat > TMAX) ? TMAX : sat);
      chk({tag, "_pulse"}, N'(bus.done), N'(0));
      chk({tag, "_total"}, N'(bus.lines_total), N'(model_total));
      chk({tag, "_held"}, bus.board_out, exp_b);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] b;
      bit seen;
      int guard;
      bus.pause = 1'b0;
      bus.start = 1'b0;
      bus.clear_total = 1'b0;
      bus.board_in = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_zeroed("reset");
      rst_n = 1'b1;

      run_pass("empty", '0, 0, 0, 0, 1'b0);

      b = '0;
      b[19*W +: W] = '1;
      b[18*W +: W] = 10'b0000000001;
      run_pass("one_row", b, 0, 0, 0, 1'b0);

      b = '0;
      b[19*W +: W] = '1;
      b[17*W +: W] = '1;
      b[18*W +: W] = 10'b1111111110;
      b[16*W +: W] = 10'b0000000001;
      run_pass("two_rows", b, 0, 0, 0, 1'b0);
      run_pass("two_rows_pause", b, 5, 5, 0, 1'b0);

      b = '0;
      b[0 +: W] = '1;
      b[19*W +: W] = 10'b1010101010;
      run_pass("top_row", b, 0, 0, 0, 1'b0);
      run_pass("done_pause", b, 0, 0, 3, 1'b0);

      run_pass("full", '1, 0, 0, 0, 1'b0);

      guard = 0;
      while (model_total < TMAX && guard < 300) begin
         run_pass("sat", '1, 0, 0, 0, 1'b0);
         guard++;
      end
      run_pass("sat_hold", '1, 0, 0, 0, 1'b0);
      chk("sat_value", N'(bus.lines_total), N'(TMAX));
      run_pass("clr_done", '1, 0, 0, 0, 1'b1);

      b = '0;
      b[19*W +: W] = '1;
      b[18*W +: W] = 10'b0000000001;
      run_pass("pre_rst", b, 0, 0, 0, 1'b0);

      // Reset while the engine sits in SHIFT (row 19 full).
      @(negedge clk);
      bus.board_in = b;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", N'(bus.busy), N'(1));
      rst_n = 1'b0;
      #1;
      chk_zeroed("rst_mid");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_total = 0;
      seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      chk("rst_no_done", N'(seen), N'(0));

      run_pass("post_rst", rand_board(), 0, 0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         int pl, pa;
         pl = (i % 3 == 0) ? int'($urandom_range(5)) : 0;
         pa = int'($urandom_range(H - 6, 2));
         run_pass("rand", rand_board(), pa, pl, (i % 7 == 0) ? 2 : 0, (i % 11 == 5));
      end

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
